// File: rtl/pc_trace_pkg.sv
// rtl/pc_trace_pkg.sv - shared types and constants for the PC trace monitor
// Contents:
//   state_e      FSM encoding seen on state_o (IDLE=0, ARMED=1, POST=2, FROZEN=3)
//   CAUSE_RANGE  bit of cause_o set by a PC outside the legal window
//   CAUSE_CYCLE  bit of cause_o set by the cycle budget expiring
package pc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  localparam int CAUSE_RANGE = 0;
  localparam int CAUSE_CYCLE = 1;

endpackage

// File: rtl/pc_trace_monitor_if.sv
// rtl/pc_trace_monitor_if.sv - retire and readout bus between core/bench and the trace monitor
// Signals:
//   valid_i, pc_i, inst_i          retire strobe and retired {PC, instruction}
//   rd_en_i, rd_idx_i              readout request, logical index (0 = oldest)
//   rd_valid_o, rd_pc_o, rd_inst_o registered readout response
// Modports:
//   master  core or bench side (drives retire and read requests)
//   slave   monitor side
interface pc_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            valid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     inst_i;
  logic            rd_en_i;
  logic [AW-1:0]   rd_idx_i;
  logic            rd_valid_o;
  logic [XLEN-1:0] rd_pc_o;
  logic [31:0]     rd_inst_o;

  modport master (
    output valid_i, pc_i, inst_i, rd_en_i, rd_idx_i,
    input  rd_valid_o, rd_pc_o, rd_inst_o
  );

  modport slave (
    input  valid_i, pc_i, inst_i, rd_en_i, rd_idx_i,
    output rd_valid_o, rd_pc_o, rd_inst_o
  );

endinterface

// File: rtl/trace_ring_buf.sv
// rtl/trace_ring_buf.sv - DEPTH x {PC, instruction} storage with one write port and a registered read port
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset (read registers only)
//   wr_en_i, wr_addr_i           write strobe and physical address
//   wr_pc_i, wr_inst_i           write data
//   rd_en_i                      read request this cycle
//   rd_hit_i                     requested logical index holds a valid entry
//   rd_addr_i                    physical read address
//   rd_valid_o, rd_pc_o, rd_inst_o  registered read response
module trace_ring_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [31:0]     wr_inst_i,
  input  logic            rd_en_i,
  input  logic            rd_hit_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [31:0]     rd_inst_o
);

  logic [XLEN+31:0] mem_q [DEPTH];
  logic             rd_valid_q;
  logic [XLEN-1:0]  rd_pc_q;
  logic [31:0]      rd_inst_q;

  // Storage is deliberately not reset; the entry count gates what is readable.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= {wr_pc_i, wr_inst_i};
    end
  end

  // The array read samples pre-edge contents, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_inst_q  <= '0;
    end else if (rd_en_i) begin
      rd_valid_q <= rd_hit_i;
      if (rd_hit_i) begin
        {rd_pc_q, rd_inst_q} <= mem_q[rd_addr_i];
      end else begin
        rd_pc_q   <= '0;
        rd_inst_q <= '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_pc_o    = rd_pc_q;
  assign rd_inst_o  = rd_inst_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// rtl/pc_trace_monitor.sv - retire trace capture with PC window and cycle budget checks
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   arm_i          start/restart capture from IDLE or FROZEN
//   bus            retire and readout bus (slave side)
//   state_o        FSM state (pc_trace_pkg::state_e encoding)
//   trig_o         sticky trigger flag
//   cause_o        bit0 range violation, bit1 cycle limit
//   cycle_cnt_o    completed ARMED+POST cycles, saturating
//   entries_o      valid trace entries, saturates at DEPTH
//   halt_req_o     core halt request, high while FROZEN
module pc_trace_monitor
  import pc_trace_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter logic [XLEN-1:0] PC_LO      = '0,
  parameter logic [XLEN-1:0] PC_HI      = XLEN'(32'h18),
  parameter int              MAX_CYCLES = 16,
  parameter int              POST_TRIG  = 4,
  parameter int              CW         = 32,
  localparam int             AW         = $clog2(DEPTH),
  localparam int             EW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm_i,
  pc_trace_monitor_if.slave bus,
  output logic [1:0]    state_o,
  output logic          trig_o,
  output logic [1:0]    cause_o,
  output logic [CW-1:0] cycle_cnt_o,
  output logic [EW-1:0] entries_o,
  output logic          halt_req_o
);

  localparam int            PW       = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam logic [EW-1:0] ENT_MAX  = EW'(DEPTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [EW-1:0]   entries_q, entries_d;
  logic [CW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [PW-1:0]   post_cnt_q, post_cnt_d;
  logic            trig_q, trig_d;
  logic [1:0]      cause_q, cause_d;

  logic            wr_en;
  logic [XLEN:0]   lo_diff;
  logic            pc_below;
  logic            pc_above;
  logic            range_fire;
  logic            cyc_fire;
  logic [AW-1:0]   rd_addr;
  logic            rd_hit;

  // Borrow out of the extended subtraction gives pc < PC_LO without a
  // constant-false compare when PC_LO is zero.
  assign lo_diff    = {1'b0, bus.pc_i} - {1'b0, PC_LO};
  assign pc_below   = lo_diff[XLEN];
  assign pc_above   = (bus.pc_i >= PC_HI);
  assign range_fire = bus.valid_i && (pc_below || pc_above);
  assign cyc_fire   = (MAX_CYCLES != 0) && (cycle_cnt_q == CYC_LAST);

  // Oldest entry sits 'entries' slots behind the write pointer; entries==DEPTH
  // truncates to 0, which is exactly the wrapped case.
  assign rd_addr = wr_ptr_q - entries_q[AW-1:0] + bus.rd_idx_i;
  assign rd_hit  = bus.rd_en_i && ({1'b0, bus.rd_idx_i} < entries_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    entries_d   = entries_q;
    cycle_cnt_d = cycle_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_d      = trig_q;
    cause_d     = cause_q;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_FROZEN: begin
        if (arm_i) begin
          state_d     = ST_ARMED;
          wr_ptr_d    = '0;
          entries_d   = '0;
          cycle_cnt_d = '0;
          trig_d      = 1'b0;
          cause_d     = 2'b00;
        end
      end

      ST_ARMED, ST_POST: begin
        if (cycle_cnt_q != CNT_MAX) begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
        end

        if (bus.valid_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (entries_q != ENT_MAX) begin
            entries_d = entries_q + EW'(1);
          end
        end

        if (state_q == ST_ARMED) begin
          if (range_fire || cyc_fire) begin
            trig_d               = 1'b1;
            cause_d              = 2'b00;
            cause_d[CAUSE_RANGE] = range_fire;
            cause_d[CAUSE_CYCLE] = cyc_fire;
            if (POST_TRIG == 0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d    = ST_POST;
              post_cnt_d = PW'(POST_TRIG);
            end
          end
        end else begin
          post_cnt_d = post_cnt_q - PW'(1);
          if (post_cnt_q == PW'(1)) begin
            state_d = ST_FROZEN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      entries_q   <= '0;
      cycle_cnt_q <= '0;
      post_cnt_q  <= '0;
      trig_q      <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      entries_q   <= entries_d;
      cycle_cnt_q <= cycle_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_q      <= trig_d;
      cause_q     <= cause_d;
    end
  end

  trace_ring_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_ptr_q),
    .wr_pc_i    (bus.pc_i),
    .wr_inst_i  (bus.inst_i),
    .rd_en_i    (bus.rd_en_i),
    .rd_hit_i   (rd_hit),
    .rd_addr_i  (rd_addr),
    .rd_valid_o (bus.rd_valid_o),
    .rd_pc_o    (bus.rd_pc_o),
    .rd_inst_o  (bus.rd_inst_o)
  );

  assign state_o     = state_q;
  assign trig_o      = trig_q;
  assign cause_o     = cause_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign entries_o   = entries_q;
  assign halt_req_o  = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_pc_trace_monitor.sv
// tb/tb_pc_trace_monitor.sv - directed self-checking bench for pc_trace_monitor
module tb_pc_trace_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: MAX_CYCLES=0, PC_HI=0x18.  B: MAX_CYCLES=0, PC_HI=0x100.  C: MAX_CYCLES=16, PC_HI=0x18.
  pc_trace_monitor_if #(.XLEN(32), .DEPTH(16)) bus_a ();
  pc_trace_monitor_if #(.XLEN(32), .DEPTH(16)) bus_b ();
  pc_trace_monitor_if #(.XLEN(32), .DEPTH(16)) bus_c ();

  logic        arm_a, arm_b, arm_c;
  logic [1:0]  state_a, state_b, state_c;
  logic        trig_a, trig_b, trig_c;
  logic [1:0]  cause_a, cause_b, cause_c;
  logic [31:0] cyc_a, cyc_b, cyc_c;
  logic [4:0]  ent_a, ent_b, ent_c;
  logic        halt_a, halt_b, halt_c;

  pc_trace_monitor #(.XLEN(32), .DEPTH(16), .PC_LO(32'h0), .PC_HI(32'h18),
                     .MAX_CYCLES(0), .POST_TRIG(4), .CW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_a), .bus(bus_a),
    .state_o(state_a), .trig_o(trig_a), .cause_o(cause_a),
    .cycle_cnt_o(cyc_a), .entries_o(ent_a), .halt_req_o(halt_a));

  pc_trace_monitor #(.XLEN(32), .DEPTH(16), .PC_LO(32'h0), .PC_HI(32'h100),
                     .MAX_CYCLES(0), .POST_TRIG(4), .CW(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_b), .bus(bus_b),
    .state_o(state_b), .trig_o(trig_b), .cause_o(cause_b),
    .cycle_cnt_o(cyc_b), .entries_o(ent_b), .halt_req_o(halt_b));

  pc_trace_monitor #(.XLEN(32), .DEPTH(16), .PC_LO(32'h0), .PC_HI(32'h18),
                     .MAX_CYCLES(16), .POST_TRIG(4), .CW(32)) dut_c (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_c), .bus(bus_c),
    .state_o(state_c), .trig_o(trig_c), .cause_o(cause_c),
    .cycle_cnt_o(cyc_c), .entries_o(ent_c), .halt_req_o(halt_c));

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (state_a !== 2'd0 || trig_a !== 1'b0 || cause_a !== 2'b00 || halt_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d trig=%0b cause=%b halt=%0b want 0/0/00/0", state_a, trig_a, cause_a, halt_a);
    end
    checks++;
    if (cyc_a !== 32'd0 || ent_a !== 5'd0) begin
      errors++;
      $display("FAIL reset_counts: cycle=%0d entries=%0d want 0/0", cyc_a, ent_a);
    end
    checks++;
    if (bus_a.rd_valid_o !== 1'b0 || bus_a.rd_pc_o !== 32'h0 || bus_a.rd_inst_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd: valid=%0b pc=%h inst=%h want 0/0/0", bus_a.rd_valid_o, bus_a.rd_pc_o, bus_a.rd_inst_o);
    end
    checks++;
  endtask

  task automatic test_capture();
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    if (state_a !== 2'd1) begin
      errors++;
      $display("FAIL cap_armed: state=%0d want 1", state_a);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      bus_a.valid_i = 1'b1;
      bus_a.pc_i    = 32'(4 * i);
      bus_a.inst_i  = inst_of(32'(4 * i));
      tick();
    end
    bus_a.valid_i = 1'b0;
    if (ent_a !== 5'd6 || trig_a !== 1'b0 || state_a !== 2'd1) begin
      errors++;
      $display("FAIL cap_status: entries=%0d trig=%0b state=%0d want 6/0/1", ent_a, trig_a, state_a);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      bus_a.rd_en_i  = 1'b1;
      bus_a.rd_idx_i = 4'(i);
      if (i == 0) begin
        #1;
        if (bus_a.rd_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL cap_latency: rd_valid=%0b before edge want 0", bus_a.rd_valid_o);
        end
        checks++;
      end
      tick();
      if (bus_a.rd_valid_o !== 1'b1 || bus_a.rd_pc_o !== 32'(4 * i) || bus_a.rd_inst_o !== inst_of(32'(4 * i))) begin
        errors++;
        $display("FAIL cap_read%0d: valid=%0b pc=%h inst=%h want 1/%h/%h", i, bus_a.rd_valid_o,
                 bus_a.rd_pc_o, bus_a.rd_inst_o, 32'(4 * i), inst_of(32'(4 * i)));
      end
      checks++;
    end
    bus_a.rd_en_i = 1'b0;
    tick();
    if (bus_a.rd_valid_o !== 1'b0 || bus_a.rd_pc_o !== 32'h14) begin
      errors++;
      $display("FAIL cap_hold: valid=%0b pc=%h want 0/14", bus_a.rd_valid_o, bus_a.rd_pc_o);
    end
    checks++;
  endtask

  task automatic test_range_trigger();
    logic [31:0] pcs [7];
    pcs = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28};
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus_c.valid_i = 1'b1;
      bus_c.pc_i    = pcs[i];
      bus_c.inst_i  = inst_of(pcs[i]);
      tick();
      if (i == 1 && trig_c !== 1'b0) begin
        errors++;
        $display("FAIL rng_early: trig=%0b want 0", trig_c);
      end
      if (i == 1) checks++;
      if (i == 2) begin
        if (trig_c !== 1'b1 || cause_c !== 2'b01 || state_c !== 2'd2) begin
          errors++;
          $display("FAIL rng_trig: trig=%0b cause=%b state=%0d want 1/01/2", trig_c, cause_c, state_c);
        end
        checks++;
      end
      if (i == 5) begin
        if (state_c !== 2'd2) begin
          errors++;
          $display("FAIL rng_post3: state=%0d want 2", state_c);
        end
        checks++;
      end
    end
    bus_c.valid_i = 1'b0;
    if (state_c !== 2'd3 || halt_c !== 1'b1 || ent_c !== 5'd7 || cyc_c !== 32'd7) begin
      errors++;
      $display("FAIL rng_frozen: state=%0d halt=%0b entries=%0d cycle=%0d want 3/1/7/7", state_c, halt_c, ent_c, cyc_c);
    end
    checks++;
    bus_c.rd_en_i  = 1'b1;
    bus_c.rd_idx_i = 4'd6;
    tick();
    bus_c.rd_en_i = 1'b0;
    if (bus_c.rd_valid_o !== 1'b1 || bus_c.rd_pc_o !== 32'h28) begin
      errors++;
      $display("FAIL rng_read6: valid=%0b pc=%h want 1/28", bus_c.rd_valid_o, bus_c.rd_pc_o);
    end
    checks++;
  endtask

  task automatic test_wrap();
    arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_b.valid_i = 1'b1;
      bus_b.pc_i    = 32'(4 * i);
      bus_b.inst_i  = inst_of(32'(4 * i));
      tick();
    end
    bus_b.valid_i = 1'b0;
    if (ent_b !== 5'd16 || trig_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_entries: entries=%0d trig=%0b want 16/0", ent_b, trig_b);
    end
    checks++;
    bus_b.rd_en_i  = 1'b1;
    bus_b.rd_idx_i = 4'd0;
    tick();
    if (bus_b.rd_valid_o !== 1'b1 || bus_b.rd_pc_o !== 32'h10 || bus_b.rd_inst_o !== 32'h1300_0010) begin
      errors++;
      $display("FAIL wrap_idx0: valid=%0b pc=%h inst=%h want 1/10/13000010", bus_b.rd_valid_o, bus_b.rd_pc_o, bus_b.rd_inst_o);
    end
    checks++;
    bus_b.rd_idx_i = 4'd15;
    tick();
    bus_b.rd_en_i = 1'b0;
    if (bus_b.rd_valid_o !== 1'b1 || bus_b.rd_pc_o !== 32'h4C) begin
      errors++;
      $display("FAIL wrap_idx15: valid=%0b pc=%h want 1/4c", bus_b.rd_valid_o, bus_b.rd_pc_o);
    end
    checks++;
    // Out-of-range PC freezes B so it can be re-armed.
    bus_b.valid_i = 1'b1;
    bus_b.pc_i    = 32'h200;
    bus_b.inst_i  = inst_of(32'h200);
    tick();
    bus_b.valid_i = 1'b0;
    if (trig_b !== 1'b1 || cause_b !== 2'b01) begin
      errors++;
      $display("FAIL wrap_trig: trig=%0b cause=%b want 1/01", trig_b, cause_b);
    end
    checks++;
    for (int i = 0; i < 4; i++) tick();
    arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    if (state_b !== 2'd1 || ent_b !== 5'd0) begin
      errors++;
      $display("FAIL wrap_rearm: state=%0d entries=%0d want 1/0", state_b, ent_b);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      bus_b.valid_i = 1'b1;
      bus_b.pc_i    = 32'h80 + 32'(4 * i);
      bus_b.inst_i  = inst_of(32'h80 + 32'(4 * i));
      tick();
    end
    bus_b.valid_i  = 1'b0;
    bus_b.rd_en_i  = 1'b1;
    bus_b.rd_idx_i = 4'd1;
    tick();
    if (bus_b.rd_valid_o !== 1'b1 || bus_b.rd_pc_o !== 32'h84) begin
      errors++;
      $display("FAIL wrap_new1: valid=%0b pc=%h want 1/84", bus_b.rd_valid_o, bus_b.rd_pc_o);
    end
    checks++;
    bus_b.rd_idx_i = 4'd2;
    tick();
    bus_b.rd_en_i = 1'b0;
    if (bus_b.rd_valid_o !== 1'b0 || bus_b.rd_pc_o !== 32'h0 || bus_b.rd_inst_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_beyond: valid=%0b pc=%h inst=%h want 0/0/0", bus_b.rd_valid_o, bus_b.rd_pc_o, bus_b.rd_inst_o);
    end
    checks++;
  endtask

  task automatic test_cycle_limit();
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    if (state_c !== 2'd1 || cyc_c !== 32'd0 || trig_c !== 1'b0 || cause_c !== 2'b00 || ent_c !== 5'd0) begin
      errors++;
      $display("FAIL cyc_rearm: state=%0d cycle=%0d trig=%0b cause=%b entries=%0d want 1/0/0/00/0",
               state_c, cyc_c, trig_c, cause_c, ent_c);
    end
    checks++;
    for (int i = 0; i < 15; i++) tick();
    if (trig_c !== 1'b0 || state_c !== 2'd1 || cyc_c !== 32'd15) begin
      errors++;
      $display("FAIL cyc_15: trig=%0b state=%0d cycle=%0d want 0/1/15", trig_c, state_c, cyc_c);
    end
    checks++;
    tick();
    if (trig_c !== 1'b1 || cause_c !== 2'b10 || state_c !== 2'd2 || cyc_c !== 32'd16) begin
      errors++;
      $display("FAIL cyc_16: trig=%0b cause=%b state=%0d cycle=%0d want 1/10/2/16", trig_c, cause_c, state_c, cyc_c);
    end
    checks++;
    for (int i = 0; i < 3; i++) tick();
    if (state_c !== 2'd2) begin
      errors++;
      $display("FAIL cyc_post3: state=%0d want 2", state_c);
    end
    checks++;
    tick();
    if (state_c !== 2'd3 || cyc_c !== 32'd20 || halt_c !== 1'b1) begin
      errors++;
      $display("FAIL cyc_frozen: state=%0d cycle=%0d halt=%0b want 3/20/1", state_c, cyc_c, halt_c);
    end
    checks++;
    tick();
    tick();
    if (cyc_c !== 32'd20 || cause_c !== 2'b10) begin
      errors++;
      $display("FAIL cyc_hold: cycle=%0d cause=%b want 20/10", cyc_c, cause_c);
    end
    checks++;
  endtask

  task automatic test_both_causes();
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    bus_c.valid_i = 1'b1;
    bus_c.pc_i    = 32'h40;
    bus_c.inst_i  = inst_of(32'h40);
    tick();
    bus_c.valid_i = 1'b0;
    if (cause_c !== 2'b11 || trig_c !== 1'b1 || state_c !== 2'd2) begin
      errors++;
      $display("FAIL both_cause: cause=%b trig=%0b state=%0d want 11/1/2", cause_c, trig_c, state_c);
    end
    checks++;
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    if (state_c !== 2'd2 || trig_c !== 1'b1 || cause_c !== 2'b11) begin
      errors++;
      $display("FAIL both_armpost: state=%0d trig=%0b cause=%b want 2/1/11", state_c, trig_c, cause_c);
    end
    checks++;
    for (int i = 0; i < 3; i++) tick();
    if (state_c !== 2'd3 || ent_c !== 5'd1 || cyc_c !== 32'd20) begin
      errors++;
      $display("FAIL both_frozen: state=%0d entries=%0d cycle=%0d want 3/1/20", state_c, ent_c, cyc_c);
    end
    checks++;
    arm_c = 1'b1;
    tick();
    arm_c = 1'b0;
    if (state_c !== 2'd1 || cyc_c !== 32'd0 || trig_c !== 1'b0 || cause_c !== 2'b00 || ent_c !== 5'd0 || halt_c !== 1'b0) begin
      errors++;
      $display("FAIL both_rearm: state=%0d cycle=%0d trig=%0b cause=%b entries=%0d halt=%0b want 1/0/0/00/0/0",
               state_c, cyc_c, trig_c, cause_c, ent_c, halt_c);
    end
    checks++;
  endtask

  task automatic test_reset_mid_post();
    // C is ARMED with cycle_cnt 0 on entry.
    bus_c.valid_i = 1'b1;
    bus_c.pc_i    = 32'h8;
    bus_c.inst_i  = inst_of(32'h8);
    tick();
    bus_c.valid_i = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    if (state_c !== 2'd2 || ent_c !== 5'd1) begin
      errors++;
      $display("FAIL rst_pre: state=%0d entries=%0d want 2/1", state_c, ent_c);
    end
    checks++;
    #3;
    rst_n = 1'b0;
    #1;
    if (state_c !== 2'd0 || trig_c !== 1'b0 || ent_c !== 5'd0 || halt_c !== 1'b0 || cause_c !== 2'b00 || cyc_c !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: state=%0d trig=%0b entries=%0d halt=%0b cause=%b cycle=%0d want all 0",
               state_c, trig_c, ent_c, halt_c, cause_c, cyc_c);
    end
    checks++;
    #2;
    rst_n = 1'b1;
    bus_c.rd_en_i  = 1'b1;
    bus_c.rd_idx_i = 4'd0;
    tick();
    bus_c.rd_en_i = 1'b0;
    if (bus_c.rd_valid_o !== 1'b0 || bus_c.rd_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_read: valid=%0b pc=%h want 0/0", bus_c.rd_valid_o, bus_c.rd_pc_o);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0;
    arm_a = 1'b0; arm_b = 1'b0; arm_c = 1'b0;
    bus_a.valid_i = 1'b0; bus_a.pc_i = '0; bus_a.inst_i = '0; bus_a.rd_en_i = 1'b0; bus_a.rd_idx_i = '0;
    bus_b.valid_i = 1'b0; bus_b.pc_i = '0; bus_b.inst_i = '0; bus_b.rd_en_i = 1'b0; bus_b.rd_idx_i = '0;
    bus_c.valid_i = 1'b0; bus_c.pc_i = '0; bus_c.inst_i = '0; bus_c.rd_en_i = 1'b0; bus_c.rd_idx_i = '0;
    #8;
    test_reset();
    #4;
    rst_n = 1'b1;
    tick();
    test_capture();
    test_range_trigger();
    test_wrap();
    test_cycle_limit();
    test_both_causes();
    test_reset_mid_post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_trace_monitor.md
Name: pc_trace_monitor

Overview:
Synthesizable, parametrised successor to the per-cycle PC/instruction diagnostic bench. It captures retired {PC, instruction} pairs into a circular trace buffer and checks every PC against an allowed address window. It also enforces a cycle budget; on a violation it records a fixed post-trigger window, then freezes and requests a core halt. It sits beside the core on the retire interface, with a registered readout port for debug or bench use.

Parameters:
XLEN, 32, PC/data width
DEPTH, 16, trace entries; power of two, >= 2
PC_LO, 32'h0, lowest legal PC (inclusive)
PC_HI, 32'h18, legal PC upper bound (exclusive)
MAX_CYCLES, 16, cycle budget while capturing; 0 disables the cycle check
POST_TRIG, 4, cycles captured after a trigger; 0 means freeze immediately
CW, 32, cycle counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arm_i  in  1  start/restart capture (pulse)
valid_i  in  1  retire strobe
pc_i  in  XLEN  retired PC
inst_i  in  32  retired instruction
rd_en_i  in  1  readout request
rd_idx_i  in  $clog2(DEPTH)  logical index; 0 = oldest
rd_valid_o  out  1  readout data valid
rd_pc_o  out  XLEN  readout PC
rd_inst_o  out  32  readout instruction
state_o  out  2  FSM state
trig_o  out  1  sticky trigger flag
cause_o  out  2  bit0 = range violation, bit1 = cycle limit
cycle_cnt_o  out  CW  completed ARMED+POST cycles
entries_o  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
halt_req_o  out  1  high in FROZEN

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE. trig_o, cause_o, cycle_cnt_o, entries_o, write pointer, post counter, rd_valid_o, rd_pc_o, rd_inst_o and halt_req_o are all 0. Storage contents are not reset; entries=0 makes them unreadable.
- States: IDLE=0, ARMED=1, POST=2, FROZEN=3.
- IDLE / FROZEN:
  - arm_i moves the FSM to ARMED on the next edge.
  - On that edge it clears wr_ptr, entries, cycle_cnt, trig and cause.
- ARMED / POST:
  - arm_i is ignored.
  - cycle_cnt increments every cycle and saturates at 2^CW-1.
- Capture (ARMED and POST only):
  - valid_i writes {pc_i, inst_i} at wr_ptr.
  - wr_ptr advances mod DEPTH; on wrap the oldest entry is overwritten.
  - entries increments and saturates at DEPTH.
- Range check (ARMED only): fires when valid_i && (pc_i < PC_LO || pc_i >= PC_HI). The violating entry is still stored.
- Cycle check (ARMED only): fires when MAX_CYCLES != 0 and cycle_cnt == MAX_CYCLES-1, i.e. during the MAX_CYCLES-th armed cycle.
- Trigger:
  - On the edge that ends the triggering cycle: trig_o=1, cause_o latches the firing checks (both firing gives 2'b11).
  - Next state is POST with post_cnt=POST_TRIG, or FROZEN if POST_TRIG==0.
- POST:
  - No further checks; cause_o is unchanged.
  - post_cnt decrements every cycle. On the edge where post_cnt goes 1 to 0, move to FROZEN. POST therefore lasts exactly POST_TRIG cycles.
- FROZEN: no writes, cycle_cnt holds, halt_req_o=1. trig_o and cause_o hold until re-arm or reset.
- Readout (any state, 1-cycle latency):
  - Physical index = (wr_ptr - entries + rd_idx_i) mod DEPTH.
  - rd_valid_o = rd_en_i && rd_idx_i < entries, registered.
  - Data is registered. When not valid, data is 0.
  - A read and a write in the same cycle return the pre-write view.
  - Without rd_en_i, rd_valid_o drops to 0 and data holds.
- Width rules: PC compares are unsigned XLEN. Pointer arithmetic is mod DEPTH.
- Mid-operation reset: immediate return to the reset values above, from any state.

Decomposition:
- Package pc_trace_pkg holds:
  - state enum (IDLE/ARMED/POST/FROZEN)
  - cause bit positions (CAUSE_RANGE=0, CAUSE_CYCLE=1)
- Sub-module trace_ring_buf:
  - DEPTH x (XLEN+32) storage
  - one write port and one registered read port
- The FSM, counters and checks live in the top.

Test Plan:
1. MAX_CYCLES=0; arm; PCs 0x0,0x4..0x14 valid on consecutive cycles -> no trigger, entries_o=6, state ARMED; reads idx 0..5 return 0x0..0x14 with rd_valid_o one cycle after rd_en_i.
2. PCs 0x10,0x14,0x18 then 0x1C,0x20,0x24,0x28 (POST_TRIG=4) -> trig_o=1 after 0x18 with cause_o=01; FROZEN after 4 POST cycles; halt_req_o=1; entries_o=7; read idx 6 = 0x28.
3. PC_HI=0x100, MAX_CYCLES=0; 20 in-range PCs 0x0..0x4C -> entries_o=16; idx0=0x10, idx15=0x4C; read of idx ≥ entries after re-arm gives rd_valid_o=0 and data 0.
4. MAX_CYCLES=16, valid_i=0 -> trigger on 16th armed cycle with cause_o=10; FROZEN 4 cycles later; cycle_cnt_o frozen at 20.
5. MAX_CYCLES=16, out-of-range PC 0x40 on the 16th armed cycle -> cause_o=11; arm_i during POST is ignored; arm_i in FROZEN -> ARMED with counters, trig and cause cleared.
6. Assert rst_n low mid-POST -> state_o=0, trig_o=0, entries_o=0, halt_req_o=0 asynchronously; subsequent read gives rd_valid_o=0.
